// File: rtl/ext_pipe.sv
// Pipelined immediate extender (sign/zero/high/branch/ones); latency = STAGES cycles, one beat per cycle.
// Backpressure: per-stage valid/ready with bubble compression; a flush kills every in-flight beat.
module ext_pipe #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int EXT_W = OUT_W - IN_W;

  localparam logic [2:0] OP_SIGN   = 3'd0;
  localparam logic [2:0] OP_ZERO   = 3'd1;
  localparam logic [2:0] OP_HIGH   = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_ONES   = 3'd4;

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] ext_dat;
  logic             ext_err;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] err_q, err_d;
  logic [STAGES-1:0] rdy;
  logic [OUT_W-1:0]  dat_q [STAGES];
  logic [OUT_W-1:0]  dat_d [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic              accept;

  assign sign_ext = {{EXT_W{in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    ext_dat = '0;
    ext_err = 1'b0;
    case (in_op)
      OP_SIGN:   ext_dat = sign_ext;
      OP_ZERO:   ext_dat = {{EXT_W{1'b0}}, in_imm};
      OP_HIGH:   ext_dat = {in_imm, {EXT_W{1'b0}}};
      OP_BRANCH: ext_dat = sign_ext << 2;
      OP_ONES:   ext_dat = {{EXT_W{1'b1}}, in_imm};
      default:   ext_err = 1'b1;
    endcase
  end

  // Stage i may load if any stage at or after it is empty, or the sink is taking the tail.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < STAGES; i++) begin
      rdy[i] = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!vld_q[j]) rdy[i] = 1'b1;
      end
    end
  end

  assign in_ready = rdy[0] && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    vld_d = vld_q;
    err_d = err_q;
    dat_d = dat_q;
    tag_d = tag_q;
    if (rdy[0]) vld_d[0] = accept;
    if (accept) begin
      dat_d[0] = ext_dat;
      tag_d[0] = in_tag;
      err_d[0] = ext_err;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (rdy[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_d[i] = dat_q[i-1];
          tag_d[i] = tag_q[i-1];
          err_d[i] = err_q[i-1];
        end
      end
    end
    // Flush wins over any advancement on the same edge.
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        dat_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      dat_q <= dat_d;
      tag_q <= tag_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_data  = dat_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_err   = err_q[STAGES-1];

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the pipelined datapath.
- Takes an IN_W-bit immediate and an extension mode, and produces an OUT_W-bit result after STAGES register stages.
- Uses a valid/ready handshake, tag passthrough and synchronous flush, so it can sit between decode and execute and stall or flush with the pipeline.

Parameters:
- IN_W, 16, immediate input width (legal 8..OUT_W-2).
- OUT_W, 32, result width (legal IN_W+2..64).
- STAGES, 2, number of register stages (legal 1..4); sets the latency.
- TAG_W, 5, width of the sideband tag carried alongside the data (e.g. destination register).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit accepts the input beat this cycle.
- in_imm  in  IN_W  immediate to extend.
- in_op  in  3  extension mode.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W  extended result.
- out_tag  out  TAG_W  tag travelling with the result.
- out_err  out  1  in_op was a reserved code.

Behaviour:
- Reset: asynchronous on reset_n low. All stage valid bits, data, tags and err bits clear to 0, so out_valid=0, out_data=0, out_tag=0 and out_err=0. in_ready=1 while reset_n=1 and flush=0.
- Modes (computed combinationally into stage 1; stages 2..STAGES are pure delay):
  - op 0 SIGN: {(OUT_W-IN_W){imm[IN_W-1]}, imm}.
  - op 1 ZERO: {(OUT_W-IN_W){0}, imm}.
  - op 2 HIGH (lui): {imm, (OUT_W-IN_W){0}}.
  - op 3 BRANCH: SIGN result shifted left by 2. The upper bits are dropped, which is lossless given the legal widths.
  - op 4 ONES: {(OUT_W-IN_W){1}, imm}.
  - ops 5-7 reserved: data=0, err=1.
- Stage handshake: stage i loads when ready_i = !valid_i || ready_{i+1}. The ready after the last stage is out_ready. in_ready = ready_1 && !flush.
- Transfer: an input is accepted on in_valid && in_ready.
- Latency and throughput: STAGES cycles from accept to out_valid with no backpressure; one beat per cycle sustained.
- Stalls: while out_valid && !out_ready, out_data, out_tag and out_err hold stable and no stage data is overwritten. The pipeline compresses bubbles: an empty stage still loads even when downstream is stalled.
- Ordering: beats emerge in acceptance order; none are lost or duplicated.
- Flush: on a clock edge with flush=1, every stage valid bit clears.
  - in_ready is 0 that cycle, so a simultaneous in_valid is dropped.
  - A simultaneous out_valid && out_ready completes as a transfer this cycle.
  - Stage data and tag registers need not be cleared; out_data is don't-care while out_valid=0.
- Flush priority: flush overrides out_ready-driven advancement on the same edge.
- Mid-operation reset: reset_n low at any point discards all in-flight beats immediately (asynchronous). The first accept is allowed on the first rising edge after reset_n returns high.
- Bubbles: in_valid=0 cycles propagate as bubbles. out_valid never asserts without a prior accepted beat.

Test Plan:
- Defaults, back-to-back, no backpressure:
  - op0 imm 0x8000 -> out_data 0xFFFF8000, out_valid exactly 2 cycles after accept.
  - op1 0x8000 -> 0x00008000.
  - op2 0x1234 -> 0x12340000.
  - op3 0xFFFF -> 0xFFFFFFFC.
  - op4 0x0001 -> 0xFFFF0001.
  - Required: one result per cycle, tags 1..5 in order.
- Reserved op: op6 imm 0x1234 tag 7 -> out_data 0x00000000, out_err=1, out_tag 7.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while streaming 4 beats. Required: in_ready drops after 2 beats are held (STAGES=2); out_data stays stable.
  - Release out_ready. Required: 4 results emerge in order with no loss or duplication.
- Flush:
  - Flush with 2 beats in flight plus in_valid=1 on the same edge. Required: next cycle out_valid=0 and all three beats are gone.
  - A beat accepted the following cycle appears 2 cycles later.
- Reset mid-stream: drop reset_n asynchronously between edges with beats in flight. Required: out_valid=0 immediately and out_data=0; after release, a SIGN 0x7FFF beat yields 0x00007FFF.
- Parameter sweep: IN_W=8, OUT_W=16, STAGES=1.
  - op0 0x80 -> 0xFF80, 1-cycle latency.
  - op2 0xAB -> 0xAB00.
  - STAGES=4: 4-cycle latency, with in_ready held high under continuous out_ready=1.
